// File: rtl/ppu_vram_arb.sv
// Request/grant scheduler for the shared PPU VRAM bus: sprite fetcher > background fetcher > register interface.
// Optional ageing of register-interface requests is enabled by defining PPU_VRAM_ARB_AGE_EN.
module ppu_vram_arb #(
  parameter int ACCESS_CYCLES = 2,
  parameter int RI_MAX_LOSSES = 4
) (
  input  logic        clk_in,
  input  logic        nrst_in,
  input  logic        spr_req_in,
  input  logic [13:0] spr_a_in,
  output logic        spr_gnt_out,
  output logic        spr_rdy_out,
  input  logic        bg_req_in,
  input  logic [13:0] bg_a_in,
  output logic        bg_gnt_out,
  output logic        bg_rdy_out,
  input  logic        ri_req_in,
  input  logic        ri_wr_in,
  input  logic [13:0] ri_a_in,
  input  logic [7:0]  ri_d_in,
  output logic        ri_gnt_out,
  output logic        ri_rdy_out,
  output logic [7:0]  rd_d_out,
  output logic        busy_out,
  input  logic [7:0]  vram_d_in,
  output logic [13:0] vram_a_out,
  output logic [7:0]  vram_d_out,
  output logic        vram_wr_out
);

  if (ACCESS_CYCLES < 2 || ACCESS_CYCLES > 15) begin : g_bad_access_cycles
    $error("ppu_vram_arb: ACCESS_CYCLES must be within 2..15");
  end
  if (RI_MAX_LOSSES < 1 || RI_MAX_LOSSES > 15) begin : g_bad_ri_max_losses
    $error("ppu_vram_arb: RI_MAX_LOSSES must be within 1..15");
  end

  localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic [1:0] {OWN_SPR, OWN_BG, OWN_RI} owner_t;

  state_t      state_q, state_d;
  owner_t      owner_q, owner_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [13:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        any_req;
  logic        ri_force;
  logic        ri_wins;

  assign any_req = spr_req_in | bg_req_in | ri_req_in;
  assign ri_wins = ri_req_in & (ri_force | (~spr_req_in & ~bg_req_in));

`ifdef PPU_VRAM_ARB_AGE_EN
  logic [3:0] loss_q, loss_d;

  assign ri_force = (loss_q == 4'(RI_MAX_LOSSES));

  // Counts consecutive arbitrations ri lost; only IDLE cycles are arbitrations.
  always_comb begin
    loss_d = loss_q;
    if (state_q == IDLE) begin
      if (!ri_req_in || ri_wins) loss_d = '0;
      else if (loss_q != 4'hF)   loss_d = loss_q + 4'd1;
    end
  end

  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) loss_q <= '0;
    else          loss_q <= loss_d;
  end
`else
  assign ri_force = 1'b0;
`endif

  // Requesters hold req/address until their one-cycle gnt, then drop req;
  // rdy marks completion and rd_d_out stays valid until the next read capture.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = ACCESS;
          cnt_d   = '0;
          wr_d    = 1'b0;
          if (ri_wins) begin
            owner_d = OWN_RI;
            addr_d  = ri_a_in;
            wdata_d = ri_d_in;
            wr_d    = ri_wr_in;
          end else if (spr_req_in) begin
            owner_d = OWN_SPR;
            addr_d  = spr_a_in;
          end else begin
            owner_d = OWN_BG;
            addr_d  = bg_a_in;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          cnt_d   = '0;
          if (!wr_q) rd_d = vram_d_in;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      state_q <= IDLE;
      owner_q <= OWN_SPR;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
    end
  end

  logic grant_cyc;
  assign grant_cyc = (state_q == ACCESS) && (cnt_q == 4'd0);

  assign spr_gnt_out = grant_cyc && (owner_q == OWN_SPR);
  assign bg_gnt_out  = grant_cyc && (owner_q == OWN_BG);
  assign ri_gnt_out  = grant_cyc && (owner_q == OWN_RI);
  assign spr_rdy_out = (state_q == DONE) && (owner_q == OWN_SPR);
  assign bg_rdy_out  = (state_q == DONE) && (owner_q == OWN_BG);
  assign ri_rdy_out  = (state_q == DONE) && (owner_q == OWN_RI);
  assign busy_out    = (state_q == ACCESS);
  assign rd_d_out    = rd_q;
  assign vram_a_out  = addr_q;
  assign vram_d_out  = wdata_q;
  // Strobe drops on the final access cycle so address/data are held past it.
  assign vram_wr_out = (state_q == ACCESS) && wr_q && (cnt_q != LAST_CNT);

endmodule

// File: tb/tb_ppu_vram_arb.sv
// Directed bench for ppu_vram_arb: a 2-cycle instance for most scenarios and a 5-cycle instance for capture timing.
module tb_ppu_vram_arb;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        spr_req = 1'b0, bg_req = 1'b0, ri_req = 1'b0, ri_wr = 1'b0;
  logic [13:0] spr_a = '0, bg_a = '0, ri_a = '0;
  logic [7:0]  ri_d = '0, vram_d_in = '0;

  logic        spr_gnt, spr_rdy, bg_gnt, bg_rdy, ri_gnt, ri_rdy, busy, vram_wr;
  logic [7:0]  rd_d, vram_d;
  logic [13:0] vram_a;

  logic        x5_spr_gnt, x5_spr_rdy, x5_bg_gnt, x5_bg_rdy, x5_ri_gnt, x5_ri_rdy, x5_busy, x5_vram_wr;
  logic [7:0]  x5_rd_d, x5_vram_d;
  logic [13:0] x5_vram_a;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ppu_vram_arb #(.ACCESS_CYCLES(2), .RI_MAX_LOSSES(4)) dut (
    .clk_in(clk), .nrst_in(nrst),
    .spr_req_in(spr_req), .spr_a_in(spr_a), .spr_gnt_out(spr_gnt), .spr_rdy_out(spr_rdy),
    .bg_req_in(bg_req), .bg_a_in(bg_a), .bg_gnt_out(bg_gnt), .bg_rdy_out(bg_rdy),
    .ri_req_in(ri_req), .ri_wr_in(ri_wr), .ri_a_in(ri_a), .ri_d_in(ri_d),
    .ri_gnt_out(ri_gnt), .ri_rdy_out(ri_rdy), .rd_d_out(rd_d), .busy_out(busy),
    .vram_d_in(vram_d_in), .vram_a_out(vram_a), .vram_d_out(vram_d), .vram_wr_out(vram_wr)
  );

  ppu_vram_arb #(.ACCESS_CYCLES(5), .RI_MAX_LOSSES(4)) dut5 (
    .clk_in(clk), .nrst_in(nrst),
    .spr_req_in(spr_req), .spr_a_in(spr_a), .spr_gnt_out(x5_spr_gnt), .spr_rdy_out(x5_spr_rdy),
    .bg_req_in(bg_req), .bg_a_in(bg_a), .bg_gnt_out(x5_bg_gnt), .bg_rdy_out(x5_bg_rdy),
    .ri_req_in(ri_req), .ri_wr_in(ri_wr), .ri_a_in(ri_a), .ri_d_in(ri_d),
    .ri_gnt_out(x5_ri_gnt), .ri_rdy_out(x5_ri_rdy), .rd_d_out(x5_rd_d), .busy_out(x5_busy),
    .vram_d_in(vram_d_in), .vram_a_out(x5_vram_a), .vram_d_out(x5_vram_d), .vram_wr_out(x5_vram_wr)
  );

  task automatic do_reset;
    spr_req = 1'b0; bg_req = 1'b0; ri_req = 1'b0; ri_wr = 1'b0;
    nrst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    logic [60:0] obs;
    nrst = 1'b0;
    @(posedge clk); #1;
    obs = {spr_gnt, spr_rdy, bg_gnt, bg_rdy, ri_gnt, ri_rdy, rd_d, busy, vram_a, vram_d, vram_wr,
           x5_busy, x5_vram_a};
    n_checks++;
    if (obs !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h, expected 0", obs);
    end
    @(negedge clk); nrst = 1'b1;
    @(negedge clk); @(negedge clk);
    obs = {spr_gnt, spr_rdy, bg_gnt, bg_rdy, ri_gnt, ri_rdy, rd_d, busy, vram_a, vram_d, vram_wr,
           x5_busy, x5_vram_a};
    n_checks++;
    if (obs !== '0) begin
      n_fail++; $display("FAIL reset_idle: got %h, expected 0", obs);
    end
  endtask

  task automatic test_bg_read;
    int wr_hi = 0;
    do_reset;
    bg_req = 1'b1; bg_a = 14'h23C0; vram_d_in = 8'h5A;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      wr_hi += int'(vram_wr);
      n_checks++;
      if ({bg_gnt, bg_rdy, busy} !== {k == 1, k == 3, k <= 2}) begin
        n_fail++; $display("FAIL bg_read_ctl k=%0d: got %b, expected %b", k, {bg_gnt, bg_rdy, busy}, {k == 1, k == 3, k <= 2});
      end
      n_checks++;
      if (vram_a !== 14'h23C0) begin
        n_fail++; $display("FAIL bg_read_addr k=%0d: got %h, expected 23c0", k, vram_a);
      end
      if (k == 3) begin
        n_checks++;
        if (rd_d !== 8'h5A) begin
          n_fail++; $display("FAIL bg_read_data: got %h, expected 5a", rd_d);
        end
      end
      if (k == 1) bg_req = 1'b0;
    end
    n_checks++;
    if (wr_hi !== 0) begin
      n_fail++; $display("FAIL bg_read_nowrite: got %0d strobe cycles, expected 0", wr_hi);
    end
  endtask

  // Runs straight after test_bg_read, so rd_d_out still holds 8'h5A.
  task automatic test_ri_write;
    int wr_hi = 0;
    ri_req = 1'b1; ri_wr = 1'b1; ri_a = 14'h2005; ri_d = 8'h7F; vram_d_in = 8'hC3;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      wr_hi += int'(vram_wr);
      n_checks++;
      if ({ri_gnt, ri_rdy, vram_wr, busy} !== {k == 1, k == 3, k == 1, k <= 2}) begin
        n_fail++; $display("FAIL ri_write_ctl k=%0d: got %b, expected %b", k, {ri_gnt, ri_rdy, vram_wr, busy}, {k == 1, k == 3, k == 1, k <= 2});
      end
      if (k <= 2) begin
        n_checks++;
        if ({vram_a, vram_d} !== {14'h2005, 8'h7F}) begin
          n_fail++; $display("FAIL ri_write_bus k=%0d: got %h/%h, expected 2005/7f", k, vram_a, vram_d);
        end
      end
      n_checks++;
      if (rd_d !== 8'h5A) begin
        n_fail++; $display("FAIL ri_write_rd_hold k=%0d: got %h, expected 5a", k, rd_d);
      end
      if (k == 1) ri_req = 1'b0;
    end
    n_checks++;
    if (wr_hi !== 1) begin
      n_fail++; $display("FAIL ri_write_strobe_count: got %0d, expected 1", wr_hi);
    end
    ri_wr = 1'b0;
  endtask

  task automatic test_priority;
    logic [2:0]  exp_gnt, exp_rdy;
    do_reset;
    spr_a = 14'h0100; bg_a = 14'h0200; ri_a = 14'h0300; ri_wr = 1'b0;
    spr_req = 1'b1; bg_req = 1'b1; ri_req = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      exp_gnt = {k == 1, k == 5, k == 9};
      exp_rdy = {k == 3, k == 7, k == 11};
      n_checks++;
      if ({spr_gnt, bg_gnt, ri_gnt} !== exp_gnt) begin
        n_fail++; $display("FAIL prio_gnt k=%0d: got %b, expected %b", k, {spr_gnt, bg_gnt, ri_gnt}, exp_gnt);
      end
      n_checks++;
      if ({spr_rdy, bg_rdy, ri_rdy} !== exp_rdy) begin
        n_fail++; $display("FAIL prio_rdy k=%0d: got %b, expected %b", k, {spr_rdy, bg_rdy, ri_rdy}, exp_rdy);
      end
      if (k == 1 || k == 5 || k == 9) begin
        n_checks++;
        if (vram_a !== ((k == 1) ? 14'h0100 : (k == 5) ? 14'h0200 : 14'h0300)) begin
          n_fail++; $display("FAIL prio_addr k=%0d: got %h", k, vram_a);
        end
      end
      if (k == 1) spr_req = 1'b0;
      if (k == 5) bg_req  = 1'b0;
      if (k == 9) ri_req  = 1'b0;
    end
  endtask

  task automatic test_age;
    logic exp_bg, exp_ri;
    logic age_en;
`ifdef PPU_VRAM_ARB_AGE_EN
    age_en = 1'b1;
`else
    age_en = 1'b0;
`endif
    do_reset;
    bg_a = 14'h00AA; ri_a = 14'h0155; ri_wr = 1'b0;
    bg_req = 1'b1; ri_req = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      exp_ri = age_en && (k == 17);
      exp_bg = (k % 4 == 1) && !exp_ri;
      n_checks++;
      if ({bg_gnt, ri_gnt} !== {exp_bg, exp_ri}) begin
        n_fail++; $display("FAIL age_gnt k=%0d: got bg/ri %b, expected %b", k, {bg_gnt, ri_gnt}, {exp_bg, exp_ri});
      end
      if (exp_ri) ri_req = 1'b0;
    end
    bg_req = 1'b0; ri_req = 1'b0;
  endtask

  task automatic test_reset_mid;
    do_reset;
    ri_req = 1'b1; ri_wr = 1'b1; ri_a = 14'h2005; ri_d = 8'h7F;
    @(negedge clk);
    n_checks++;
    if ({vram_wr, busy, vram_a} !== {1'b1, 1'b1, 14'h2005}) begin
      n_fail++; $display("FAIL rst_mid_pre: got %b/%b/%h, expected 1/1/2005", vram_wr, busy, vram_a);
    end
    ri_req = 1'b0; ri_wr = 1'b0;
    #2 nrst = 1'b0;
    #1;
    n_checks++;
    if ({vram_wr, busy, vram_a, ri_gnt} !== '0) begin
      n_fail++; $display("FAIL rst_mid_async: got %b/%b/%h/%b, expected all 0", vram_wr, busy, vram_a, ri_gnt);
    end
    @(negedge clk); nrst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_checks++;
      if ({spr_rdy, bg_rdy, ri_rdy, busy} !== 4'b0000) begin
        n_fail++; $display("FAIL rst_mid_no_rdy k=%0d: got %b, expected 0000", k, {spr_rdy, bg_rdy, ri_rdy, busy});
      end
    end
  endtask

  task automatic test_ac5_capture;
    do_reset;
    spr_a = 14'h1FF8; spr_req = 1'b1; vram_d_in = 8'hA0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      vram_d_in = 8'hA0 + 8'(k);
      if (k == 1) spr_req = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({x5_spr_gnt, x5_spr_rdy, x5_busy, x5_vram_wr} !== {k == 1, k == 6, k <= 5, 1'b0}) begin
        n_fail++; $display("FAIL ac5_ctl k=%0d: got %b, expected %b", k, {x5_spr_gnt, x5_spr_rdy, x5_busy, x5_vram_wr}, {k == 1, k == 6, k <= 5, 1'b0});
      end
      n_checks++;
      if (x5_vram_a !== 14'h1FF8) begin
        n_fail++; $display("FAIL ac5_addr k=%0d: got %h, expected 1ff8", k, x5_vram_a);
      end
      n_checks++;
      if (x5_rd_d !== ((k >= 6) ? 8'hA5 : 8'h00)) begin
        n_fail++; $display("FAIL ac5_rd k=%0d: got %h, expected %h", k, x5_rd_d, (k >= 6) ? 8'hA5 : 8'h00);
      end
    end
  endtask

  initial begin
    test_reset;
    test_bg_read;
    test_ri_write;
    test_priority;
    test_age;
    test_reset_mid;
    test_ac5_capture;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
